// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   NOP_INSTR     : instruction presented to decode out of reset (addi x0,x0,0)
//   PC_STEP_DEF   : default sequential PC increment
package fetch_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      HOLD = 3'd2,
      DROP = 3'd3,
      HALT = 3'd4
   } fetch_state_e;

   localparam logic [31:0]  NOP_INSTR   = 32'h0000_0013;
   localparam int unsigned  PC_STEP_DEF = 4;

endpackage

// File: rtl/pc_fetch_unit_pc_adder.sv
// PC adder: y = a + b, wrapping modulo 2^W.
//   a, b : operands (W bits)
//   y    : sum (W bits, carry out discarded)
module PC_Adder #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetch stage.
// Fetches from imem over req/ack and presents {instr, pc, pc+step} to decode
// over valid/ready. Redirects from execute flush in-flight work.
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction memory handshake
//   redirect_valid/redirect_pc      : branch/jump target from execute
//   out_valid/out_ready             : decode handshake
//   out_instr/out_pc/out_pc_plus4   : fetched instruction bundle
//   fetch_misalign                  : misaligned redirect flag (FETCH_MISALIGN_TRAP_EN only)
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch
// instead of clearing the low target bits.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     PC_STEP      = PC_STEP_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic            fetch_misalign,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_pc_plus4
);

   localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
   localparam logic [XLEN-1:0] RESET_PLUS = RESET_VECTOR + STEP;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] tgt_q, tgt_d;
   logic [XLEN-1:0] pc_plus_c;
   logic [XLEN-1:0] rd_tgt_c;
   logic [XLEN-1:0] addr_d, opc_d, opc4_d;
   logic [31:0]     instr_d;
   logic            req_d, valid_d;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic            mis_c;
   logic            mis_d;
`endif

   PC_Adder #(.W(XLEN)) u_pc_adder (
      .a (pc_q),
      .b (STEP),
      .y (pc_plus_c)
   );

   // Word-aligned redirect target; identical to redirect_pc when aligned.
   assign rd_tgt_c = redirect_pc & ~XLEN'(2'b11);

`ifdef FETCH_MISALIGN_TRAP_EN
   assign mis_c = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; redirect takes priority over ack/handshake
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (redirect_valid) state_d = imem_ack ? REQ : DROP;
            else if (imem_ack)  state_d = HOLD;
         end
         HOLD: if (redirect_valid || out_ready) state_d = REQ;
         DROP: if (imem_ack) state_d = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: if (redirect_valid) state_d = REQ;
`endif
         default: state_d = IDLE;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      if (mis_c) state_d = HALT;
`endif
   end

   // Next values for PC, stored target and registered outputs
   always_comb begin
      pc_d    = pc_q;
      tgt_d   = tgt_q;
      instr_d = out_instr;
      opc_d   = out_pc;
      opc4_d  = out_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_d   = fetch_misalign;
`endif
      case (state_q)
         IDLE: if (redirect_valid) pc_d = rd_tgt_c;
         REQ, DROP: begin
            // A redirect without ack must keep imem_addr: park it in tgt
            if (redirect_valid) begin
               if (imem_ack) pc_d  = rd_tgt_c;
               else          tgt_d = rd_tgt_c;
            end else if (imem_ack) begin
               if (state_q == REQ) begin
                  instr_d = imem_rdata;
                  opc_d   = pc_q;
                  opc4_d  = pc_plus_c;
               end else begin
                  pc_d = tgt_q;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) pc_d = rd_tgt_c;
            else if (out_ready) pc_d = pc_plus_c;
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         HALT: begin
            if (redirect_valid) begin
               pc_d  = rd_tgt_c;
               mis_d = 1'b0;
            end
         end
`endif
         default: ;
      endcase
`ifdef FETCH_MISALIGN_TRAP_EN
      // Misaligned target: report it unmodified and fetch nothing
      if (mis_c) begin
         pc_d    = pc_q;
         tgt_d   = tgt_q;
         instr_d = out_instr;
         opc_d   = redirect_pc;
         opc4_d  = out_pc_plus4;
         mis_d   = 1'b1;
      end
`endif
      req_d   = (state_d == REQ) || (state_d == DROP);
      valid_d = (state_d == HOLD);
      addr_d  = (state_d == REQ) ? pc_d : imem_addr;
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q           <= RESET_VECTOR;
         tgt_q          <= RESET_VECTOR;
         imem_req       <= 1'b0;
         imem_addr      <= RESET_VECTOR;
         out_valid      <= 1'b0;
         out_instr      <= NOP_INSTR;
         out_pc         <= RESET_VECTOR;
         out_pc_plus4   <= RESET_PLUS;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_misalign <= 1'b0;
`endif
      end else begin
         pc_q           <= pc_d;
         tgt_q          <= tgt_d;
         imem_req       <= req_d;
         imem_addr      <= addr_d;
         out_valid      <= valid_d;
         out_instr      <= instr_d;
         out_pc         <= opc_d;
         out_pc_plus4   <= opc4_d;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_misalign <= mis_d;
`endif
      end
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential owner of the program counter; consumer of the PC adder's pc+4 result.
- Fetches instructions from instruction memory over a req/ack handshake and hands {instr, pc, pc+4} to decode over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and flushes in-flight work.
- Sits between imem and decode in the RISC-V core.

Parameters:
- XLEN, 32, width of PC and addresses.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset.
- PC_STEP, 4, sequential increment added to the PC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  XLEN  fetch address; stable while imem_req=1.
- imem_ack  in  1  memory returns data this cycle; ignored unless imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- redirect_valid  in  1  take redirect_pc this cycle.
- redirect_pc  in  XLEN  new fetch target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts when out_valid=1.
- out_instr  out  32  fetched instruction.
- out_pc  out  XLEN  address of out_instr.
- out_pc_plus4  out  XLEN  out_pc+PC_STEP, modulo 2^XLEN.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (async assert, any state):
  - State=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR.
  - out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=RESET_VECTOR, out_pc_plus4=RESET_VECTOR+PC_STEP.
  - A request outstanding at reset is abandoned; the imem side must drop it.
- State machine:
  - IDLE: entered for exactly one cycle after reset release, then REQ.
  - REQ: imem_req=1, imem_addr=pc.
    - On imem_ack: latch imem_rdata, pc, pc+4; go to HOLD; out_valid=1 the next cycle.
    - Zero-wait ack is legal: ack in the first REQ cycle gives 1-cycle request-to-valid latency.
  - HOLD: out_valid=1; outputs are stable while waiting.
    - On out_valid&out_ready: pc<=pc+PC_STEP, go to REQ.
    - Throughput: at most one instruction per 2 cycles with zero-wait memory.
  - DROP: imem_req stays 1 with the old address until imem_ack. That ack's data is discarded; then go to REQ at the redirected pc.
- Redirects (redirect has priority over all other events):
  - REQ, no ack this cycle: store target in pc_next and go to DROP. imem_addr must not change mid-request.
  - REQ, ack same cycle: discard imem_rdata, pc<=redirect_pc, go to REQ.
  - HOLD, with or without out_ready: held instruction is flushed (not consumed), out_valid=0 next cycle, pc<=redirect_pc, go to REQ.
  - DROP: a newer redirect overwrites the stored target; the last one wins.
  - IDLE: pc<=redirect_pc.
- Arithmetic: pc+PC_STEP wraps modulo 2^XLEN (32'hFFFF_FFFC+4=0). No overflow flag.
- Alignment (macro absent): redirect_pc[1:0] are forced to 2'b00 on load.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets fetch_misalign=1, loads out_pc=redirect_pc unmodified, issues no fetch and enters state HALT.
  - HALT holds out_valid=0 until the next redirect with an aligned target, which clears fetch_misalign and resumes in REQ.
- Undefined: no port, no HALT state; low bits are forced to zero.

Decomposition:
- Package fetch_pkg: state enum {IDLE, REQ, HOLD, DROP, HALT}, NOP_INSTR=32'h0000_0013, default PC_STEP.
- Sub-module: one instance of the existing PC_Adder (a=pc, b=PC_STEP) produces pc+4. No other sub-modules.

Test Plan:
- Reset release, zero-wait memory, out_ready=1 -> first imem_addr=0x0, then 0x4 and 0x8; out_pc sequence 0,4,8; out_pc_plus4 sequence 4,8,C.
- imem_ack delayed 3 cycles -> imem_addr stays 0x0 for all 3 cycles; out_valid rises one cycle after ack.
- out_ready=0 for 5 cycles in HOLD -> out_instr/out_pc stable; no new imem_req until handshake.
- Redirect to 0x100 while waiting for ack at 0x8 -> ack data discarded, never presented; next imem_addr=0x100.
- Redirect in HOLD with out_ready=1 -> instruction flushed; next out_pc=target. Wrap check: pc=0xFFFF_FFFC handshake -> next imem_addr=0x0.
- Macro defined: redirect to 0x102 -> fetch_misalign=1, no imem_req; redirect to 0x200 -> fetch_misalign=0, fetch at 0x200. Async reset mid-DROP -> all outputs at reset values immediately.
